// File: rtl/vga_timing_rx.sv
// VGA sync receiver: measures hsync/vsync timing, locks to the
// expected mode, and emits de, x/y coordinates and a frame strobe.
module vga_timing_rx #(
  parameter int HTOTAL      = 800,
  parameter int HSYNC       = 96,
  parameter int HBP         = 48,
  parameter int HACT        = 640,
  parameter int VTOTAL      = 521,
  parameter int VSYNC       = 2,
  parameter int VBP         = 29,
  parameter int VACT        = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic        locked,
  output logic        de,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic [10:0] h_period,
  output logic [10:0] h_width,
  output logic [10:0] v_period,
  output logic [10:0] v_width
);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [10:0] HSAT = 11'(2 * HTOTAL);
  localparam logic [10:0] VSAT = 11'(2 * VTOTAL);
  localparam logic [10:0] C_HT = 11'(HTOTAL);
  localparam logic [10:0] C_HS = 11'(HSYNC);
  localparam logic [10:0] C_VT = 11'(VTOTAL);
  localparam logic [10:0] C_VS = 11'(VSYNC);
  localparam logic [10:0] HLO  = 11'(HSYNC + HBP);
  localparam logic [10:0] HHI  = 11'(HSYNC + HBP + HACT);
  localparam logic [10:0] VLO  = 11'(VSYNC + VBP);
  localparam logic [10:0] VHI  = 11'(VSYNC + VBP + VACT);
  localparam logic [7:0]  C_LF = 8'(LOCK_FRAMES);

  logic        hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;
  logic        hs_prev_q, vs_prev_q;
  logic [10:0] hcnt_q, vcnt_q;
  logic [10:0] hper_q, hwid_q, vper_q, vwid_q;
  logic        h_err_q, armed_q, armed_d;
  logic [1:0]  state_q, state_d;
  logic [7:0]  good_q, good_d;
  logic        locked_q, de_q, fs_q, fs_d;
  logic [9:0]  x_q, y_q;

  logic        hfall, hrise, vfall, vrise;
  logic [10:0] hcnt_p1, vcnt_n;
  logic        sat, herr_now, frame_good, de_d;

  assign hfall = pix_ce & hs_prev_q & ~hs_s2_q;
  assign hrise = pix_ce & ~hs_prev_q & hs_s2_q;
  assign vfall = pix_ce & vs_prev_q & ~vs_s2_q;
  assign vrise = pix_ce & ~vs_prev_q & vs_s2_q;

  assign hcnt_p1 = hcnt_q + 11'd1;
  assign vcnt_n  = hfall ? vcnt_q + 11'd1 : vcnt_q;
  assign sat     = (hcnt_q == HSAT) | (vcnt_q == VSAT);

  assign herr_now = (hfall & armed_q & (hcnt_p1 != C_HT))
                  | (hrise & (hcnt_p1 != C_HS));

  assign frame_good = ~(h_err_q | herr_now)
                    & (vcnt_n == C_VT)
                    & (vwid_q == C_VS);

  assign de_d = locked_q
              & (hcnt_q >= HLO) & (hcnt_q < HHI)
              & (vcnt_q >= VLO) & (vcnt_q < VHI);

  // two-flop synchronizers, every clk
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_s1_q <= 1'b1;
      hs_s2_q <= 1'b1;
      vs_s1_q <= 1'b1;
      vs_s2_q <= 1'b1;
    end else begin
      hs_s1_q <= hsync_in;
      hs_s2_q <= hs_s1_q;
      vs_s1_q <= vsync_in;
      vs_s2_q <= vs_s1_q;
    end
  end

  // lock state machine, judged at vsync falls
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    if (pix_ce && sat) begin
      state_d = SEARCH;
    end else if (vfall) begin
      case (state_q)
        SEARCH: begin
          state_d = VERIFY;
          good_d  = 8'd0;
        end
        VERIFY: begin
          if (frame_good) begin
            good_d = good_q + 8'd1;
            if (good_q + 8'd1 == C_LF)
              state_d = LOCKED;
          end else begin
            good_d = 8'd0;
          end
        end
        LOCKED: begin
          if (!frame_good)
            state_d = SEARCH;
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // the first line after losing lock is partial, so skip it
  always_comb begin
    armed_d = armed_q;
    if (state_d == SEARCH && state_q != SEARCH)
      armed_d = 1'b0;
    else if (hfall)
      armed_d = 1'b1;
  end

  assign fs_d = vfall & (state_q == LOCKED) & (state_d == LOCKED);

  // state, lock flag and judging helpers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEARCH;
      good_q   <= 8'd0;
      armed_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      armed_q  <= armed_d;
      locked_q <= (state_q == LOCKED);
    end
  end

  // line/frame counters and measurements on pixel ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      hper_q    <= '0;
      hwid_q    <= '0;
      vper_q    <= '0;
      vwid_q    <= '0;
      h_err_q   <= 1'b0;
    end else if (pix_ce) begin
      hs_prev_q <= hs_s2_q;
      vs_prev_q <= vs_s2_q;
      if (hfall)
        hcnt_q <= '0;
      else if (hcnt_q != HSAT)
        hcnt_q <= hcnt_p1;
      if (hfall)
        hper_q <= hcnt_p1;
      if (hrise)
        hwid_q <= hcnt_p1;
      if (vfall)
        vcnt_q <= '0;
      else if (hfall && vcnt_q != VSAT)
        vcnt_q <= vcnt_q + 11'd1;
      if (vfall)
        vper_q <= vcnt_n;
      if (vrise)
        vwid_q <= vcnt_n;
      if (vfall)
        h_err_q <= 1'b0;
      else if (herr_now)
        h_err_q <= 1'b1;
    end
  end

  // coordinate outputs, one pixel tick behind the counters
  always_ff @(posedge clk) begin
    if (rst) begin
      de_q <= 1'b0;
      fs_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else if (pix_ce) begin
      de_q <= de_d;
      fs_q <= fs_d;
      if (de_d) begin
        x_q <= 10'(hcnt_q - HLO);
        y_q <= 10'(vcnt_q - VLO);
      end
    end
  end

  assign locked      = locked_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign h_period    = hper_q;
  assign h_width     = hwid_q;
  assign v_period    = vper_q;
  assign v_width     = vwid_q;

endmodule

// File: doc/vga_timing_rx.md
Name: vga_timing_rx

Overview:
- Receiver side of the VGA sync interface: samples incoming active-low hsync/vsync and measures line and frame timing.
- Locks to 640x480 timing, then produces pixel coordinates, data-enable and a frame-start strobe for downstream capture/overlay logic.
- Sits between a VGA sync source (on-board generator or external port) and any pixel-consuming block.

Parameters:
- HTOTAL, 800, pixel ticks per line
- HSYNC, 96, hsync low width in ticks
- HBP, 48, horizontal back porch in ticks
- HACT, 640, active pixels per line
- VTOTAL, 521, lines per frame
- VSYNC, 2, vsync low width in lines
- VBP, 29, vertical back porch in lines
- VACT, 480, active lines
- LOCK_FRAMES, 2, consecutive good frames required for lock

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pix_ce  in  1  pixel-tick enable; all counting advances only when high
- hsync_in  in  1  asynchronous hsync, active low
- vsync_in  in  1  asynchronous vsync, active low
- locked  out  1  timing matches parameters
- de  out  1  active-video enable
- x  out  10  pixel column, valid when de
- y  out  10  pixel row, valid when de
- frame_start  out  1  one-tick pulse at frame start while locked
- h_period  out  11  last measured line length (ticks)
- h_width  out  11  last measured hsync low width (ticks)
- v_period  out  11  last measured frame length (lines)
- v_width  out  11  last measured vsync low width (lines)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - Synchronizer flops and previous-sample regs = 1.
  - hcnt, vcnt, good_cnt, all measured values, x, y = 0.
  - de, locked, frame_start = 0; state = SEARCH.
  - Reset asserted mid-frame takes effect on the next clk edge.
- Synchronizer: 2-flop synchronizer per sync input, clocked every clk.
- Edge detection: compares the synchronized value against the previous pix_ce sample; updates only on pix_ce.
- hcnt (11-bit), advances on pix_ce ticks:
  - Increments each tick, saturating at 2*HTOTAL.
  - On an hsync fall tick: h_period <= hcnt+1, hcnt <= 0.
  - On an hsync rise tick: h_width <= hcnt+1.
- vcnt (11-bit, line index):
  - Increments on each hsync fall, saturating at 2*VTOTAL.
  - On a vsync fall: v_period <= vcnt (or vcnt+1 if an hsync fall occurs on the same tick), vcnt <= 0.
  - On a vsync rise: v_width <= vcnt, with the same +1 rule.
- h_err flag:
  - Set at any hsync fall where hcnt+1 != HTOTAL, or at any hsync rise where hcnt+1 != HSYNC.
  - The first hsync fall after entering SEARCH is not judged.
  - Cleared at each vsync fall after evaluation.
- A frame is good at a vsync fall iff: h_err == 0, the computed v_period == VTOTAL, and v_width == VSYNC.
- Lock FSM, evaluated at vsync fall ticks:
  - SEARCH: go to VERIFY, good_cnt <= 0. The partial frame is not judged.
  - VERIFY, good frame: good_cnt++. When good_cnt reaches LOCK_FRAMES, go to LOCKED.
  - VERIFY, bad frame: good_cnt <= 0, remain in VERIFY.
  - LOCKED, bad frame: go to SEARCH.
  - Any state: hcnt saturated or vcnt saturated forces SEARCH on that tick.
  - locked = (state == LOCKED), registered.
- Coordinates, registered with 1 pix_ce-tick latency:
  - de = locked && HSYNC+HBP <= hcnt < HSYNC+HBP+HACT && VSYNC+VBP <= vcnt < VSYNC+VBP+VACT.
  - x = hcnt-(HSYNC+HBP), y = vcnt-(VSYNC+VBP).
  - x and y hold their last value when de is 0.
- frame_start:
  - High for exactly one pix_ce tick on a vsync fall while in LOCKED and remaining LOCKED.
  - Held low otherwise.
- Simultaneous hsync fall and vsync fall on the same tick: both counter rules apply; vcnt ends at 0.

Test Plan:
1. Nominal 640x480 timing, pix_ce every 2nd clk, 5 frames -> locked asserts at the 3rd vsync fall; h_period=800, h_width=96, v_period=521, v_width=2.
2. Locked frame -> first de with x=0, y=0 at vcnt=31, hcnt=144; last de with x=639, y=479; exactly 307200 de ticks per frame; one frame_start per frame.
3. Source with HTOTAL=799 -> locked never asserts; h_period=799; de stays 0.
4. hsync held high while locked -> locked drops once hcnt reaches 1600; state SEARCH; relock 3 vsync falls after hsync resumes.
5. rst pulsed mid-frame while locked -> next clk: locked=0, de=0, measured values=0; relock after 3 vsync falls.
6. One line with a 95-tick hsync during a locked frame -> locked drops at that frame's vsync fall; re-locks after LOCK_FRAMES further good frames (SEARCH then VERIFY).
